term_ctrl: RTL
==============

# term_ctrl

Text-terminal write controller. It accepts a byte stream over a valid/ready handshake, interprets the control codes, and sequences all writes into the character buffer that the VGA glyph renderer scans. Its duties are cursor tracking, line wrap, line clear-ahead and screen clear. It sits between the CPU/UART byte source and the write port of the dual-port character RAM. The display read side is independent of this block.

## Interface
Parameters:
- COLS, 32, characters per row (256 px / 8 px glyph width)
- ROWS, 15, rows per screen (240 px / 16 px glyph cell)
- BLANK, 8'h20, fill code written by clears and backspace

Ports:
- clk  in  1  system clock; one clock domain
- reset_n  in  1  reset, synchronous and active-low
- in_data  in  8  byte from source
- in_valid  in  1  in_data valid
- in_ready  out  1  controller can accept a byte this cycle
- wr_en  out  1  character RAM write strobe
- wr_addr  out  9  RAM address = row*COLS + col (0..479)
- wr_data  out  8  glyph code to write
- cursor_col  out  5  current column, 0..COLS-1
- cursor_row  out  4  current row, 0..ROWS-1
- busy  out  1  high during row clear or screen clear

## Operation
- A byte is accepted on a rising edge where in_valid && in_ready.
- All outputs are registered.
- States:
  - CLRSCR: writes BLANK to every address 0..ROWS*COLS-1, ascending, one per cycle.
  - IDLE: in_ready=1.
  - CLRROW: writes BLANK to the COLS addresses of cursor_row, col 0..COLS-1.
- Byte decode in IDLE:
  - 8'h0D (CR): col←0. No write. Stay IDLE.
  - 8'h0A (LF): col←0, row advances (see below), then CLRROW.
  - 8'h08 (BS): if col>0, col←col-1 and BLANK is written at the new position. If col==0, no-op.
  - 8'h0C (FF): cursor←(0,0), then CLRSCR.
  - Any other value is printable (full 256-glyph font). in_data is written at the current cursor, then col←col+1.
    - If col was COLS-1: col←0, row advances, then CLRROW.
- Row advance: row←row+1. At ROWS-1 the row wraps to 0; there is no scrolling. The entered row is always cleared (clear-ahead).
- Outside IDLE: in_ready=0 and busy=1. Source bytes are held off and never dropped.
- cursor_col/cursor_row always show the position where the next printable byte will be written.
- Reset:
  - While reset_n=0: state=CLRSCR, clear counter=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=BLANK, cursor=(0,0), busy=1.
  - Reset asserted mid-operation aborts that operation and restarts the full clear.

## Timing
- CLRSCR from reset:
  - The first edge with reset_n=1 drives wr_en=1, wr_addr=0.
  - The Nth edge drives addr N-1.
  - Edge 481 drives wr_en=0, in_ready=1, busy=0.
- Printable, no wrap:
  - The accept edge drives wr_en=1, wr_addr=old cursor, wr_data=byte, and the cursor is updated on that same edge.
  - in_ready stays 1, so throughput is 1 byte/cycle.
- Printable at col COLS-1, or LF:
  - The accept edge performs the printable write (LF: no write) and sets cursor=(0,row').
  - in_ready drops on that edge.
  - The next COLS edges write BLANK to row'*COLS+0 .. +COLS-1.
  - The following edge returns to IDLE with in_ready=1.
  - LF blocks input for COLS+1 cycles in total.
- FF: accept edge, then ROWS*COLS write cycles, then IDLE.
- BS/CR: single cycle, in_ready stays 1.
- Whenever no write is issued that cycle, wr_en=0. wr_data/wr_addr then hold their last values.
- Address arithmetic: row*COLS+col computed at 9 bits. It never exceeds ROWS*COLS-1.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release → 480 consecutive writes of 8'h20 to addresses 0..479. in_ready rises on cycle 481. Cursor=(0,0).
- Stream: after reset, send 'A','B','C' back-to-back → writes (0,8'h41),(1,8'h42),(2,8'h43) on consecutive cycles, in_ready never drops. Cursor=(3,0).
- Line wrap: 32 printable bytes at row 0 → 32nd write at addr 31. Cursor becomes (0,1). BLANK writes follow to addrs 32..63, then in_ready=1.
- Bottom wrap: cursor (5,14), send LF → cursor=(0,0). BLANK written to addrs 0..31. The source is held off for 33 cycles and no byte is lost.
- BS/CR: at (3,2), send BS → BLANK written at addr 66, cursor (2,2). Then CR → no write, cursor (0,2). Then BS at col 0 → no write, cursor unchanged.
- Mid-clear reset: send FF, assert reset_n=0 after 100 clear writes → the clear restarts at addr 0 after release and completes all 480 writes. Cursor=(0,0).

Source files
------------

// File: rtl/term_ctrl.sv
// term_ctrl: text-terminal write controller.
// Accepts a byte stream over valid/ready, decodes control codes, tracks the
// cursor and sequences every write into the character RAM, including line
// clear-ahead and full-screen clears. All outputs come straight from flops.
module term_ctrl #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned ROWS  = 15,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [4:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic       busy
);

  // Control codes recognised in the byte stream
  localparam logic [7:0] ChrBs = 8'h08;
  localparam logic [7:0] ChrLf = 8'h0A;
  localparam logic [7:0] ChrFf = 8'h0C;
  localparam logic [7:0] ChrCr = 8'h0D;

  // Clear lengths expressed in counter width
  localparam logic [8:0] ScreenCells = 9'(ROWS * COLS);
  localparam logic [8:0] RowCells    = 9'(COLS);
  localparam logic [4:0] LastCol     = 5'(COLS - 1);
  localparam logic [3:0] LastRow     = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    StClrScr,
    StIdle,
    StClrRow
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [4:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic       wr_en_q, wr_en_d;
  logic [8:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;

  // Linear RAM address of a cell; never exceeds ROWS*COLS-1 for legal inputs
  function automatic logic [8:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
    return 9'(int'(row) * int'(COLS) + int'(col));
  endfunction

  // Row advance wraps to the top; there is no scrolling
  function automatic logic [3:0] next_row(input logic [3:0] row);
    return (row == LastRow) ? 4'd0 : row + 4'd1;
  endfunction

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StClrScr;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= BLANK;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state decode; outputs are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;

    case (state_q)
      StClrScr: begin
        if (cnt_q == ScreenCells) begin
          state_d    = StIdle;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = cnt_q;
          wr_data_d  = BLANK;
          cnt_d      = cnt_q + 9'd1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      StClrRow: begin
        if (cnt_q == RowCells) begin
          state_d    = StIdle;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = cell_addr(row_q, cnt_q[4:0]);
          wr_data_d  = BLANK;
          cnt_d      = cnt_q + 9'd1;
        end
      end

      StIdle: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (in_valid) begin
          case (in_data)
            ChrCr: begin
              col_d = '0;
            end

            ChrLf: begin
              col_d      = '0;
              row_d      = next_row(row_q);
              cnt_d      = '0;
              state_d    = StClrRow;
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
            end

            ChrBs: begin
              // Erase the cell left of the cursor; at column 0 nothing happens
              if (col_q != 5'd0) begin
                col_d     = col_q - 5'd1;
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(row_q, col_q - 5'd1);
                wr_data_d = BLANK;
              end
            end

            ChrFf: begin
              col_d      = '0;
              row_d      = '0;
              cnt_d      = '0;
              state_d    = StClrScr;
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
            end

            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cell_addr(row_q, col_q);
              wr_data_d = in_data;
              if (col_q == LastCol) begin
                // Line wrap: move to the next row and clear it ahead of use
                col_d      = '0;
                row_d      = next_row(row_q);
                cnt_d      = '0;
                state_d    = StClrRow;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
              end else begin
                col_d = col_q + 5'd1;
              end
            end
          endcase
        end
      end

      default: begin
        // Unreachable encoding: recover through a full screen clear
        state_d    = StClrScr;
        cnt_d      = '0;
        col_d      = '0;
        row_d      = '0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;

endmodule
